// File: rtl/mm_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch miss controller: FSM encoding,
// default timeout and statistics counter width, and a word-alignment helper.
package mm_fetch_ctrl_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W_DEFAULT   = 20;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2,
    StDone = 2'd3
  } fetch_state_e;

  // Main memory is word addressed; byte offset bits are forced to zero.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Width-parameterised saturating up-counter with enable and synchronous clear.
module sat_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count up on enable, stick at all-ones, clear has priority.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mm_fetch_ctrl.sv
// Instruction-cache miss controller: on a miss, issues one main-memory read,
// waits for the acknowledge (or aborts after TIMEOUT cycles), strobes the fill
// into the cache and gives the cache one settle cycle before resuming.
module mm_fetch_ctrl
  import mm_fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      PC,
  input  logic             HitWrite,
  output logic             MM_REQ,
  output logic [31:0]      MM_ADDR,
  input  logic             MM_ACK,
  input  logic [31:0]      MM_DATA,
  output logic             Access_MM,
  output logic [31:0]      Data_MM,
  output logic             Stall,
  output logic             ERR,
  output logic [CNT_W-1:0] CNT_FILL,
  output logic [CNT_W-1:0] CNT_STALL
);

  // Wait counter only has to reach TIMEOUT-1: the last REQ cycle is the one
  // on which the counter equals that value.
  localparam int unsigned WaitW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WaitLastInt = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [WaitW-1:0] WaitLast = WaitLastInt[WaitW-1:0];

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [WaitW-1:0] r_wait;
  logic [31:0]      r_addr;
  logic             r_mm_req;
  logic             r_access;
  logic [31:0]      r_data;
  logic             r_err;

  logic             w_timeout;
  logic             w_req_entry;
  logic             w_fill_entry;
  logic             w_stall;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; MM_ACK only matters in REQ.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (!HitWrite) w_state_next = StReq;
      StReq:   if (MM_ACK || w_timeout) w_state_next = StFill;
      StFill:  w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM decoded outputs and transition strobes.
  always_comb begin
    w_stall      = 1'b0;
    w_timeout    = 1'b0;
    w_req_entry  = 1'b0;
    w_fill_entry = 1'b0;
    if (r_state != StIdle) begin
      w_stall = 1'b1;
    end else if (!HitWrite) begin
      w_stall = 1'b1;
    end
    if ((r_state == StReq) && (r_wait == WaitLast)) begin
      w_timeout = 1'b1;
    end
    if ((r_state == StIdle) && (w_state_next == StReq)) begin
      w_req_entry = 1'b1;
    end
    if ((r_state == StReq) && (w_state_next == StFill)) begin
      w_fill_entry = 1'b1;
    end
  end

  // Registered request/strobe outputs derived from the upcoming state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mm_req <= 1'b0;
      r_access <= 1'b0;
    end else begin
      r_mm_req <= (w_state_next == StReq);
      r_access <= (w_state_next == StFill);
    end
  end

  // Miss address latch and REQ wait counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr <= 32'h0;
      r_wait <= '0;
    end else if (w_req_entry) begin
      r_addr <= word_addr(PC);
      r_wait <= '0;
    end else if (r_state == StReq) begin
      r_wait <= r_wait + WaitW'(1);
    end
  end

  // Fill data capture; a coincident ACK beats the timeout abort.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data <= 32'h0;
      r_err  <= 1'b0;
    end else if (w_fill_entry) begin
      if (MM_ACK) begin
        r_data <= MM_DATA;
      end else begin
        r_data <= 32'h0;
        r_err  <= 1'b1;
      end
    end
  end

  sat_cnt #(
    .WIDTH(CNT_W)
  ) u_cnt_fill (
    .i_clk  (CLK),
    .i_clr  (RESET),
    .i_en   (w_fill_entry),
    .o_count(CNT_FILL)
  );

  sat_cnt #(
    .WIDTH(CNT_W)
  ) u_cnt_stall (
    .i_clk  (CLK),
    .i_clr  (RESET),
    .i_en   (w_stall),
    .o_count(CNT_STALL)
  );

  assign MM_REQ    = r_mm_req;
  assign MM_ADDR   = r_addr;
  assign Access_MM = r_access;
  assign Data_MM   = r_data;
  assign ERR       = r_err;
  assign Stall     = w_stall;

endmodule

// File: tb/tb_mm_fetch_ctrl.sv
// Scoreboard bench for mm_fetch_ctrl. Two instances share stimulus: dut_a uses
// the default parameters, dut_b uses TIMEOUT=4 and CNT_W=3. A select bit
// routes the miss signal to one instance while the other sees constant hits.
module tb_mm_fetch_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hw;
  logic        sel;
  logic        ack;
  logic [31:0] pc;
  logic [31:0] mdata;
  logic        hw_a;
  logic        hw_b;

  logic        mm_req_a, acc_a, stall_a, err_a;
  logic [31:0] mm_addr_a, data_a;
  logic [19:0] cnt_fill_a, cnt_stall_a;
  logic        mm_req_b, acc_b, stall_b, err_b;
  logic [31:0] mm_addr_b, data_b;
  logic [2:0]  cnt_fill_b, cnt_stall_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_tests = 0;
  int   n_fail = 0;
  int   pulses_a = 0, pulses_b = 0;
  int   req_cyc_a = 0, req_cyc_b = 0;
  int   mark;
  logic prev_acc_a = 1'b0, prev_acc_b = 1'b0;

  always #5 clk = ~clk;

  assign hw_a = sel ? 1'b1 : hw;
  assign hw_b = sel ? hw : 1'b1;

  mm_fetch_ctrl dut_a (
    .CLK      (clk),
    .RESET    (rst),
    .PC       (pc),
    .HitWrite (hw_a),
    .MM_REQ   (mm_req_a),
    .MM_ADDR  (mm_addr_a),
    .MM_ACK   (ack),
    .MM_DATA  (mdata),
    .Access_MM(acc_a),
    .Data_MM  (data_a),
    .Stall    (stall_a),
    .ERR      (err_a),
    .CNT_FILL (cnt_fill_a),
    .CNT_STALL(cnt_stall_a)
  );

  mm_fetch_ctrl #(
    .TIMEOUT(4),
    .CNT_W  (3)
  ) dut_b (
    .CLK      (clk),
    .RESET    (rst),
    .PC       (pc),
    .HitWrite (hw_b),
    .MM_REQ   (mm_req_b),
    .MM_ADDR  (mm_addr_b),
    .MM_ACK   (ack),
    .MM_DATA  (mdata),
    .Access_MM(acc_b),
    .Data_MM  (data_b),
    .Stall    (stall_b),
    .ERR      (err_b),
    .CNT_FILL (cnt_fill_b),
    .CNT_STALL(cnt_stall_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for dut_a: every fill strobe pops one expected fill.
  always @(negedge clk) begin
    if (mm_req_a === 1'b1) req_cyc_a++;
    if (prev_acc_a) check("a_fill_width", {31'b0, acc_a}, 32'h0);
    if (acc_a === 1'b1) begin
      pulses_a++;
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_fill: got data 0x%08h, expected no fill", data_a);
      end else begin
        e_a = q_a.pop_front();
        check("a_fill_data", data_a, e_a.data);
        check("a_fill_addr", mm_addr_a, e_a.addr);
        check("a_fill_err", {31'b0, err_a}, {31'b0, e_a.err});
      end
    end
    prev_acc_a = (acc_a === 1'b1);
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (mm_req_b === 1'b1) req_cyc_b++;
    if (prev_acc_b) check("b_fill_width", {31'b0, acc_b}, 32'h0);
    if (acc_b === 1'b1) begin
      pulses_b++;
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_fill: got data 0x%08h, expected no fill", data_b);
      end else begin
        e_b = q_b.pop_front();
        check("b_fill_data", data_b, e_b.data);
        check("b_fill_addr", mm_addr_b, e_b.addr);
        check("b_fill_err", {31'b0, err_b}, {31'b0, e_b.err});
      end
    end
    prev_acc_b = (acc_b === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hw  = 1'b1;
    ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One complete miss starting from IDLE; returns in IDLE with HitWrite=1.
  task automatic miss(input logic [31:0] p, input logic [31:0] d, input int delay,
                      input bit give_ack, input int tmo, input bit exp_err);
    exp_t e;
    e.addr = p & 32'hFFFF_FFFC;
    e.data = give_ack ? d : 32'h0;
    e.err  = exp_err;
    if (sel) q_b.push_back(e);
    else q_a.push_back(e);
    pc = p;
    hw = 1'b0;
    step();
    hw = 1'b1;
    pc = ~p;
    if (give_ack) begin
      repeat (delay) step();
      ack   = 1'b1;
      mdata = d;
      step();
      ack   = 1'b0;
      mdata = 32'h0BAD_0BAD;
    end else begin
      repeat (tmo) step();
    end
    step();
    step();
  endtask

  initial begin
    sel   = 1'b0;
    rst   = 1'b1;
    hw    = 1'b1;
    ack   = 1'b0;
    pc    = 32'h0;
    mdata = 32'h0BAD_0BAD;
    step();
    // Reset must dominate a simultaneous miss and acknowledge.
    hw  = 1'b0;
    ack = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_mm_req", {31'b0, mm_req_a}, 32'h0);
    check("rst_mm_addr", mm_addr_a, 32'h0);
    check("rst_access", {31'b0, acc_a}, 32'h0);
    check("rst_data", data_a, 32'h0);
    check("rst_err", {31'b0, err_a}, 32'h0);
    check("rst_cnt_fill", 32'(cnt_fill_a), 32'h0);
    check("rst_cnt_stall", 32'(cnt_stall_a), 32'h0);
    hw  = 1'b1;
    ack = 1'b0;
    rst = 1'b0;
    step();

    // Single miss, ACK on the first REQ cycle.
    mark = req_cyc_a;
    miss(32'h0000_0014, 32'hDEAD_BEEF, 0, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("min_stall_low", {31'b0, stall_a}, 32'h0);
    check("min_req_cycles", 32'(req_cyc_a - mark), 32'd1);
    check("min_cnt_fill", 32'(cnt_fill_a), 32'd1);
    check("min_cnt_stall", 32'(cnt_stall_a), 32'd4);

    // ACK delayed five cycles, PC disturbed during REQ, unaligned PC.
    do_reset();
    mark = req_cyc_a;
    miss(32'h0000_0103, 32'h1234_5678, 5, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("dly_req_cycles", 32'(req_cyc_a - mark), 32'd6);
    check("dly_cnt_stall", 32'(cnt_stall_a), 32'd9);
    check("dly_cnt_fill", 32'(cnt_fill_a), 32'd1);
    check("dly_err", {31'b0, err_a}, 32'h0);

    // Reset while in REQ, then a late ACK.
    do_reset();
    mark = pulses_a;
    pc = 32'h0000_0200;
    hw = 1'b0;
    step();
    hw = 1'b1;
    @(negedge clk);
    check("abort_in_req", {31'b0, mm_req_a}, 32'h1);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    ack   = 1'b1;
    mdata = 32'h7777_7777;
    step();
    ack = 1'b0;
    step();
    @(negedge clk);
    check("abort_mm_req", {31'b0, mm_req_a}, 32'h0);
    check("abort_idle_stall", {31'b0, stall_a}, 32'h0);
    check("abort_no_fill", 32'(pulses_a - mark), 32'h0);
    check("abort_data", data_a, 32'h0);
    check("abort_addr", mm_addr_a, 32'h0);
    check("abort_cnt_fill", 32'(cnt_fill_a), 32'h0);
    check("abort_cnt_stall", 32'(cnt_stall_a), 32'h0);

    // Back-to-back misses.
    do_reset();
    mark = pulses_a;
    miss(32'h0000_0040, 32'h1111_1111, 0, 1'b1, 0, 1'b0);
    miss(32'h0000_0044, 32'h2222_2222, 0, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("b2b_pulses", 32'(pulses_a - mark), 32'd2);
    check("b2b_cnt_fill", 32'(cnt_fill_a), 32'd2);
    check("b2b_cnt_stall", 32'(cnt_stall_a), 32'd8);

    // Switch to the TIMEOUT=4, CNT_W=3 instance.
    sel = 1'b1;
    do_reset();
    mark = req_cyc_b;
    miss(32'h0000_0080, 32'h9999_9999, 0, 1'b0, 4, 1'b1);
    @(negedge clk);
    check("tmo_req_cycles", 32'(req_cyc_b - mark), 32'd4);
    check("tmo_err", {31'b0, err_b}, 32'h1);
    check("tmo_data", data_b, 32'h0);
    check("tmo_cnt_fill", 32'(cnt_fill_b), 32'd1);
    miss(32'h0000_0084, 32'hCAFE_F00D, 1, 1'b1, 0, 1'b1);
    @(negedge clk);
    check("tmo_err_sticky", {31'b0, err_b}, 32'h1);
    check("tmo_cnt_fill2", 32'(cnt_fill_b), 32'd2);

    // ACK on the same cycle the timeout is reached: ACK wins.
    do_reset();
    mark = req_cyc_b;
    miss(32'h0000_0088, 32'hA5A5_5A5A, 3, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("race_req_cycles", 32'(req_cyc_b - mark), 32'd4);
    check("race_err", {31'b0, err_b}, 32'h0);
    check("race_data", data_b, 32'hA5A5_5A5A);

    // Nine misses saturate both 3-bit counters.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      miss(32'h0000_0100 + 32'(i * 4), 32'h5000_0000 + 32'(i), 0, 1'b1, 0, 1'b0);
    end
    @(negedge clk);
    check("sat_cnt_fill", 32'(cnt_fill_b), 32'd7);
    check("sat_cnt_stall", 32'(cnt_stall_b), 32'd7);
    check("sat_stall_low", {31'b0, stall_b}, 32'h0);

    check("a_queue_drained", 32'(q_a.size()), 32'h0);
    check("b_queue_drained", 32'(q_b.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_fetch_ctrl.md
MM_FETCH_CTRL -- requirements
Module: mm_fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in REQ waiting for MM_ACK before abort.
REQ-002 Parameter CNT_W, default 20: width of the statistics counters.
REQ-003 The design SHALL use one clock and a synchronous, active-high reset; all state SHALL update only on the posedge of CLK.
REQ-004 CLK  input  1  system clock.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 PC  input  32  fetch address presented to the cache.
REQ-007 HitWrite  input  1  cache hit/fill indication; 0 means miss.
REQ-008 MM_REQ  output  1  main-memory read request.
REQ-009 MM_ADDR  output  32  main-memory word address, {addr[31:2],2'b00}.
REQ-010 MM_ACK  input  1  main memory: MM_DATA valid this cycle.
REQ-011 MM_DATA  input  32  main-memory read data.
REQ-012 Access_MM  output  1  one-cycle fill strobe to the cache.
REQ-013 Data_MM  output  32  fill data to the cache.
REQ-014 Stall  output  1  freeze PC and upstream pipeline.
REQ-015 ERR  output  1  sticky timeout flag.
REQ-016 CNT_FILL  output  CNT_W  number of completed fills.
REQ-017 CNT_STALL  output  CNT_W  number of cycles with Stall=1.

Function
REQ-018 FSM states SHALL be IDLE, REQ, FILL, DONE; transitions IDLE->REQ when HitWrite=0, REQ->FILL on MM_ACK=1 or timeout, FILL->DONE unconditionally, DONE->IDLE unconditionally.
REQ-019 On the IDLE->REQ edge the block SHALL latch PC into an internal address register; MM_ADDR SHALL be driven from that register, never from live PC.
REQ-020 MM_REQ SHALL be registered, 1 exactly while in REQ, and held until MM_ACK is sampled or timeout.
REQ-021 On the REQ->FILL edge due to MM_ACK, MM_DATA SHALL be captured into Data_MM.
REQ-022 MM_ACK outside REQ SHALL be ignored.
REQ-023 A wait counter SHALL clear on REQ entry and increment each REQ cycle; on reaching TIMEOUT without MM_ACK, the block SHALL go to FILL with Data_MM=32'h0 and set ERR=1.
REQ-024 If MM_ACK and timeout coincide, MM_ACK SHALL win: data captured, ERR unchanged.
REQ-025 ERR SHALL remain 1 until RESET.
REQ-026 Access_MM SHALL be 1 exactly in FILL (one cycle per miss) and 0 otherwise.
REQ-027 Data_MM SHALL hold its last captured value outside FILL.
REQ-028 Stall SHALL be combinational: 1 when state!=IDLE, or state==IDLE and HitWrite=0.
REQ-029 In DONE, HitWrite SHALL be ignored, giving the cache one cycle to present the filled data.
REQ-030 Minimum miss penalty, from HitWrite=0 in IDLE to IDLE with Stall=0, SHALL be 4 cycles when MM_ACK arrives on the first REQ cycle.
REQ-031 CNT_FILL SHALL increment on every FILL entry, including timeout fills.
REQ-032 CNT_STALL SHALL increment every cycle Stall=1.
REQ-033 Both counters SHALL saturate at all-ones and not wrap.

Reset
REQ-034 RESET SHALL force state IDLE, MM_REQ=0, MM_ADDR=0, Access_MM=0, Data_MM=0, ERR=0, CNT_FILL=0, CNT_STALL=0, and clear the wait counter.
REQ-035 RESET asserted mid-operation SHALL abort any outstanding request at that edge; a late MM_ACK SHALL be ignored.
REQ-036 RESET SHALL take priority over all other inputs in the same cycle.

Structure
REQ-037 FSM state encoding, the TIMEOUT default, and CNT_W SHALL live in the shared cache package.
REQ-038 A single sub-module sat_cnt (width-parameterised saturating counter with enable and sync clear) SHALL implement CNT_FILL and CNT_STALL.
REQ-039 The block SHALL contain no memory arrays.

Verification
REQ-040 Reset, then HitWrite=0 with PC=32'h0000_0014 and MM_ACK on the first REQ cycle with MM_DATA=32'hDEAD_BEEF -> MM_ADDR=32'h0000_0014, Access_MM pulses 1 cycle with Data_MM=32'hDEAD_BEEF, Stall low after 4 cycles, CNT_FILL=1, CNT_STALL=4.
REQ-041 MM_ACK delayed 5 cycles -> MM_REQ high for exactly 6 cycles, PC changes during REQ do not alter MM_ADDR, CNT_STALL=9.
REQ-042 TIMEOUT=4 and MM_ACK never asserted -> after 4 REQ cycles FILL with Data_MM=0, ERR=1 and ERR stays 1 through later good fills.
REQ-043 RESET asserted in REQ, then MM_ACK the next cycle -> state IDLE, no Access_MM pulse, all counters 0.
REQ-044 Back-to-back misses (HitWrite=0 again in the cycle after DONE) -> second REQ entered immediately, two single-cycle Access_MM pulses, CNT_FILL=2.
REQ-045 CNT_W=3 with 9 misses -> CNT_FILL saturates at 7.
